regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//   Write-side front end of the integer register file. Accepts results from the ALU and LSU over
//   valid/ready handshakes and arbitrates them onto the single regfile write port.
//   The write port is registered. A pending-write scoreboard lets issue logic stall RAW hazards.
//   Sits between the execute/memory stages and regfile (drives its rd_d_i/rd_addr_i/we_i).
// PARAMETERS
//   XLEN    32   data width of results and write port
//   NREGS   32   number of architectural registers; x0 hardwired zero
//   AW      5    register address width, $clog2(NREGS)
// PORTS
//   clk_i          in   1     clock, rising edge
//   rst_n_i        in   1     reset, asynchronous, active-low
//   alu_valid_i    in   1     ALU result valid
//   alu_ready_o    out  1     ALU result accepted this cycle when valid&ready
//   alu_addr_i     in   AW    ALU destination register
//   alu_data_i     in   XLEN  ALU result
//   lsu_valid_i    in   1     LSU (load) result valid
//   lsu_ready_o    out  1     LSU result accepted this cycle when valid&ready
//   lsu_addr_i     in   AW    LSU destination register
//   lsu_data_i     in   XLEN  LSU result
//   iss_valid_i    in   1     instruction issued with destination iss_addr_i (reserve)
//   iss_addr_i     in   AW    destination being reserved
//   rs1_addr_i     in   AW    source 1 queried for pending write
//   rs2_addr_i     in   AW    source 2 queried for pending write
//   rs1_pending_o  out  1     pending[rs1_addr_i], combinational
//   rs2_pending_o  out  1     pending[rs2_addr_i], combinational
//   we_o           out  1     regfile write enable (registered)
//   rd_addr_o      out  AW    regfile write address (registered)
//   rd_d_o         out  XLEN  regfile write data (registered)
// BEHAVIOUR
//   - Reset: we_o=0, rd_addr_o=0, rd_d_o=0, hold buffer empty, pending[] all 0. Reset mid-
//     operation discards held and in-flight results; ready outputs read 1 while hold is empty.
//   - Hold buffer: one entry (addr,data) for an ALU result that lost arbitration.
//   - alu_ready_o = lsu_ready_o = !hold_valid (combinational, no dependence on valid inputs).
//   - Per-cycle winner priority: hold > LSU > ALU. Exactly one result consumed onto the port/cycle.
//     hold valid: hold written; LSU/ALU not ready. hold empty, both valid: LSU written, ALU
//     result captured into hold same edge. Single valid source: that source written.
//   - Latency: result accepted at edge N appears on we_o/rd_addr_o/rd_d_o during cycle N+1;
//     regfile commits at edge N+1. Throughput one write/cycle, no bubbles.
//   - x0: results addressed to 0 are accepted and consumed normally, but we_o stays 0 for them;
//     rd_addr_o/rd_d_o still update. pending[0] is constant 0; issue to x0 is ignored.
//   - No winner in a cycle: we_o=0 next cycle; rd_addr_o/rd_d_o hold last value.
//   - Scoreboard: iss_valid_i & iss_addr_i!=0 sets pending[iss_addr_i] at the edge.
//     we_o=1 clears pending[rd_addr_o] at the edge (same edge the regfile writes).
//     Set and clear of same address on same edge: set wins (newer reservation).
//   - rsN_pending_o=1 during the cycle we_o=1 for that register; drops to 0 the cycle the
//     regfile holds the new value (no bypass provided).
//   - Producers must hold valid/addr/data stable until accepted; unaccepted results not lost.
// TESTING
//   - Reset: assert rst_n_i=0 mid-traffic -> we_o=0, rd_*=0, pending all 0, both ready=1 at once.
//   - ALU only: addr=5 data=0xDEADBEEF valid edge N -> we_o=1 rd_addr_o=5 rd_d_o=0xDEADBEEF cycle N+1.
//   - Collision: ALU(3,0x11) + LSU(4,0x22) same cycle -> N+1 writes x4=0x22, N+2 writes x3=0x11;
//     both ready=0 during N+1; a new LSU valid in N+1 waits and writes N+3.
//   - x0: ALU addr=0 data=0x1234 -> accepted, we_o stays 0, no pending change.
//   - Scoreboard: issue x7; rs1_addr_i=7 -> rs1_pending_o=1 until edge with we_o=1 rd_addr_o=7,
//     then 0; issue x7 on that same edge -> remains 1.
//   - Back-to-back 16 ALU results addr 1..16 -> 16 consecutive we_o cycles, in order, no drops.

Source files
------------

// File: rtl/regfile_writeback.sv
// Purpose: write-side front end of the integer register file. Arbitrates ALU and
//          LSU results onto the single registered regfile write port (hold > LSU > ALU),
//          parks a losing ALU result in a one-entry hold buffer, and keeps a
//          pending-write scoreboard for RAW hazard stalls.
// Ports:
//   clk_i, rst_n_i                       clock, async active-low reset
//   alu_valid_i/alu_ready_o/alu_addr_i/alu_data_i   ALU result handshake
//   lsu_valid_i/lsu_ready_o/lsu_addr_i/lsu_data_i   LSU result handshake
//   iss_valid_i/iss_addr_i               destination reservation from issue
//   rs1_addr_i/rs2_addr_i                source queries
//   rs1_pending_o/rs2_pending_o          pending write on queried source (combinational)
//   we_o/rd_addr_o/rd_d_o                registered regfile write port
module regfile_writeback #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [AW-1:0]   alu_addr_i,
   input  logic [XLEN-1:0] alu_data_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [AW-1:0]   lsu_addr_i,
   input  logic [XLEN-1:0] lsu_data_i,
   input  logic            iss_valid_i,
   input  logic [AW-1:0]   iss_addr_i,
   input  logic [AW-1:0]   rs1_addr_i,
   input  logic [AW-1:0]   rs2_addr_i,
   output logic            rs1_pending_o,
   output logic            rs2_pending_o,
   output logic            we_o,
   output logic [AW-1:0]   rd_addr_o,
   output logic [XLEN-1:0] rd_d_o
);

   logic             hold_valid_q, hold_valid_d;
   logic [AW-1:0]    hold_addr_q, hold_addr_d;
   logic [XLEN-1:0]  hold_data_q, hold_data_d;
   logic             we_q, we_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]  rd_d_q, rd_d_d;
   logic [NREGS-1:0] pending_q, pending_d;

   logic             win_valid;
   logic [AW-1:0]    win_addr;
   logic [XLEN-1:0]  win_data;

   // Both producers are stalled only while the hold buffer drains.
   assign alu_ready_o = !hold_valid_q;
   assign lsu_ready_o = !hold_valid_q;

   // Winner selection and hold-buffer capture.
   always_comb begin
      win_valid    = 1'b0;
      win_addr     = hold_addr_q;
      win_data     = hold_data_q;
      hold_valid_d = hold_valid_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      if (hold_valid_q) begin
         win_valid    = 1'b1;
         hold_valid_d = 1'b0;
      end else if (lsu_valid_i) begin
         win_valid = 1'b1;
         win_addr  = lsu_addr_i;
         win_data  = lsu_data_i;
         // ALU is ready this cycle too, so its result must be taken now, not dropped.
         if (alu_valid_i) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = alu_addr_i;
            hold_data_d  = alu_data_i;
         end
      end else if (alu_valid_i) begin
         win_valid = 1'b1;
         win_addr  = alu_addr_i;
         win_data  = alu_data_i;
      end
   end

   // Write port: x0 results are consumed but never enable a write.
   always_comb begin
      we_d      = win_valid && (win_addr != '0);
      rd_addr_d = win_valid ? win_addr : rd_addr_q;
      rd_d_d    = win_valid ? win_data : rd_d_q;
   end

   // Scoreboard: clear on the committing edge, set afterwards so a new reservation wins.
   always_comb begin
      pending_d = pending_q;
      if (we_q) begin
         pending_d[rd_addr_q] = 1'b0;
      end
      if (iss_valid_i && (iss_addr_i != '0)) begin
         pending_d[iss_addr_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_valid_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
         we_q         <= 1'b0;
         rd_addr_q    <= '0;
         rd_d_q       <= '0;
         pending_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         we_q         <= we_d;
         rd_addr_q    <= rd_addr_d;
         rd_d_q       <= rd_d_d;
         pending_q    <= pending_d;
      end
   end

   assign we_o          = we_q;
   assign rd_addr_o     = rd_addr_q;
   assign rd_d_o        = rd_d_q;
   assign rs1_pending_o = pending_q[rs1_addr_i];
   assign rs2_pending_o = pending_q[rs2_addr_i];

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            alu_valid_i, lsu_valid_i, iss_valid_i;
   logic            alu_ready_o, lsu_ready_o;
   logic [AW-1:0]   alu_addr_i, lsu_addr_i, iss_addr_i, rs1_addr_i, rs2_addr_i;
   logic [XLEN-1:0] alu_data_i, lsu_data_i;
   logic            rs1_pending_o, rs2_pending_o, we_o;
   logic [AW-1:0]   rd_addr_o;
   logic [XLEN-1:0] rd_d_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   regfile_writeback #(.XLEN(XLEN), .NREGS(32), .AW(AW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
      .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_pending_o(rs1_pending_o), .rs2_pending_o(rs2_pending_o),
      .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_d_o(rd_d_o)
   );

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0;
      lsu_valid_i = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
      iss_valid_i = 1'b0; iss_addr_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rs1_addr_i = 5'd9; rs2_addr_i = 5'd3;
      rst_n_i = 1'b0;
      #12;
      total++; if (we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", we_o); end
      total++; if (rd_addr_o !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", rd_addr_o); end
      total++; if (rd_d_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", rd_d_o); end
      total++; if ({alu_ready_o, lsu_ready_o} !== 2'b11) begin bad++; $display("FAIL rst_ready got=%b exp=11", {alu_ready_o, lsu_ready_o}); end
      @(negedge clk_i) rst_n_i = 1'b1;
      tick();
      // Mid-traffic: reserve x9 and collide ALU/LSU so hold is full, then reset.
      iss_valid_i = 1'b1; iss_addr_i = 5'd9;
      alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h11;
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h22;
      tick();
      idle_inputs();
      total++; if ({alu_ready_o, rs1_pending_o, we_o} !== 3'b011) begin bad++; $display("FAIL pre_rst_state got=%b exp=011", {alu_ready_o, rs1_pending_o, we_o}); end
      rst_n_i = 1'b0;
      #1;
      total++; if ({we_o, rd_addr_o} !== {1'b0, 5'd0}) begin bad++; $display("FAIL midrst_we_addr got=%b/%0d exp=0/0", we_o, rd_addr_o); end
      total++; if (rd_d_o !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", rd_d_o); end
      total++; if ({alu_ready_o, lsu_ready_o, rs1_pending_o} !== 3'b110) begin bad++; $display("FAIL midrst_ready_pend got=%b exp=110", {alu_ready_o, lsu_ready_o, rs1_pending_o}); end
      @(negedge clk_i) rst_n_i = 1'b1;
      tick();
      total++; if (we_o !== 1'b0) begin bad++; $display("FAIL midrst_hold_discard got=%0b exp=0", we_o); end
   endtask

   task automatic test_alu_only();
      idle_inputs();
      alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
      total++; if (alu_ready_o !== 1'b1) begin bad++; $display("FAIL alu_ready got=%0b exp=1", alu_ready_o); end
      tick();
      idle_inputs();
      total++; if ({we_o, rd_addr_o} !== {1'b1, 5'd5}) begin bad++; $display("FAIL alu_write got=%b/%0d exp=1/5", we_o, rd_addr_o); end
      total++; if (rd_d_o !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%h exp=deadbeef", rd_d_o); end
      tick();
      total++; if ({we_o, rd_addr_o, rd_d_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin bad++; $display("FAIL alu_idle_hold got=%b/%0d/%h exp=0/5/deadbeef", we_o, rd_addr_o, rd_d_o); end
   endtask

   task automatic test_collision();
      idle_inputs();
      alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h11;
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h22;
      tick();
      // Both accepted; a new LSU result arrives while hold is full.
      alu_valid_i = 1'b0;
      lsu_addr_i = 5'd6; lsu_data_i = 32'h33;
      total++; if ({we_o, rd_addr_o, rd_d_o} !== {1'b1, 5'd4, 32'h22}) begin bad++; $display("FAIL coll_lsu got=%b/%0d/%h exp=1/4/22", we_o, rd_addr_o, rd_d_o); end
      total++; if ({alu_ready_o, lsu_ready_o} !== 2'b00) begin bad++; $display("FAIL coll_ready got=%b exp=00", {alu_ready_o, lsu_ready_o}); end
      tick();
      total++; if ({we_o, rd_addr_o, rd_d_o} !== {1'b1, 5'd3, 32'h11}) begin bad++; $display("FAIL coll_hold got=%b/%0d/%h exp=1/3/11", we_o, rd_addr_o, rd_d_o); end
      total++; if (lsu_ready_o !== 1'b1) begin bad++; $display("FAIL coll_ready_back got=%0b exp=1", lsu_ready_o); end
      tick();
      idle_inputs();
      total++; if ({we_o, rd_addr_o, rd_d_o} !== {1'b1, 5'd6, 32'h33}) begin bad++; $display("FAIL coll_waited got=%b/%0d/%h exp=1/6/33", we_o, rd_addr_o, rd_d_o); end
      tick();
      total++; if (we_o !== 1'b0) begin bad++; $display("FAIL coll_done got=%0b exp=0", we_o); end
   endtask

   task automatic test_x0();
      idle_inputs();
      rs1_addr_i = 5'd0;
      alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'h1234;
      iss_valid_i = 1'b1; iss_addr_i = 5'd0;
      tick();
      idle_inputs();
      total++; if ({we_o, rd_addr_o, rd_d_o} !== {1'b0, 5'd0, 32'h1234}) begin bad++; $display("FAIL x0_write got=%b/%0d/%h exp=0/0/1234", we_o, rd_addr_o, rd_d_o); end
      total++; if ({rs1_pending_o, alu_ready_o} !== 2'b01) begin bad++; $display("FAIL x0_pend_ready got=%b exp=01", {rs1_pending_o, alu_ready_o}); end
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      rs1_addr_i = 5'd7; rs2_addr_i = 5'd8;
      iss_valid_i = 1'b1; iss_addr_i = 5'd7;
      tick();
      idle_inputs();
      total++; if ({rs1_pending_o, rs2_pending_o} !== 2'b10) begin bad++; $display("FAIL sb_set got=%b exp=10", {rs1_pending_o, rs2_pending_o}); end
      alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h77;
      tick();
      idle_inputs();
      total++; if ({we_o, rd_addr_o, rs1_pending_o} !== {1'b1, 5'd7, 1'b1}) begin bad++; $display("FAIL sb_during_we got=%b/%0d/%b exp=1/7/1", we_o, rd_addr_o, rs1_pending_o); end
      tick();
      total++; if (rs1_pending_o !== 1'b0) begin bad++; $display("FAIL sb_clear got=%0b exp=0", rs1_pending_o); end
      // Re-reserve x7 on the same edge that commits it: set must win.
      iss_valid_i = 1'b1; iss_addr_i = 5'd7;
      tick();
      idle_inputs();
      alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h78;
      tick();
      idle_inputs();
      iss_valid_i = 1'b1; iss_addr_i = 5'd7;
      tick();
      idle_inputs();
      total++; if ({we_o, rs1_pending_o} !== 2'b01) begin bad++; $display("FAIL sb_set_wins got=%b exp=01", {we_o, rs1_pending_o}); end
      alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h79;
      tick();
      idle_inputs();
      tick();
      total++; if (rs1_pending_o !== 1'b0) begin bad++; $display("FAIL sb_final_clear got=%0b exp=0", rs1_pending_o); end
   endtask

   task automatic test_back_to_back();
      int good;
      good = 0;
      idle_inputs();
      for (int i = 1; i <= 16; i++) begin
         alu_valid_i = 1'b1;
         alu_addr_i  = AW'(i);
         alu_data_i  = 32'h100 + 32'(i);
         if (alu_ready_o !== 1'b1) $display("FAIL b2b_ready idx=%0d got=%0b exp=1", i, alu_ready_o);
         tick();
         total++;
         if ({we_o, rd_addr_o, rd_d_o} !== {1'b1, AW'(i), 32'h100 + 32'(i)}) begin
            bad++;
            $display("FAIL b2b_write idx=%0d got=%b/%0d/%h exp=1/%0d/%h", i, we_o, rd_addr_o, rd_d_o, i, 32'h100 + 32'(i));
         end else begin
            good++;
         end
      end
      idle_inputs();
      tick();
      total++; if ({good, 1'b0} !== {32'sd16, we_o}) begin bad++; $display("FAIL b2b_count got=%0d/%0b exp=16/0", good, we_o); end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_collision();
      test_x0();
      test_scoreboard();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
